ram8_arbiter: RTL and testbench
===============================

// Module: ram8_arbiter
// PURPOSE
//  Two-requester arbiter sharing one RAM8-class memory (16-bit words, 8 entries).
//  Port A is the CPU data side; port B is a DMA/peripheral side. Grants are
//  round-robin, with optional locked bursts. Drives load/address/in to the
//  memory and returns registered read data to the winning port.
// PARAMETERS
//  DATA_W     16  word width; matches the memory word.
//  ADDR_W      3  address width; 3 gives 8 words.
//  MAX_BURST   4  maximum consecutive locked beats before forced re-arbitration; must be >=1.
// PORTS
//  clk          in   1       clock; all state updates on the rising edge.
//  reset        in   1       synchronous, active-high reset.
//  a_valid      in   1       port A request present.
//  a_write      in   1       1 = write, 0 = read.
//  a_addr       in   ADDR_W  port A word address.
//  a_wdata      in   DATA_W  port A write data.
//  a_lock       in   1       port A asks to hold its grant after this beat.
//  a_ready      out  1       port A request accepted this cycle (combinational).
//  a_rvalid     out  1       port A read data valid (1-cycle pulse).
//  a_rdata      out  DATA_W  port A read data (registered).
//  b_*          --   --      same set as a_*, for port B.
//  mem_load     out  1       memory write enable.
//  mem_address  out  ADDR_W  memory address.
//  mem_in       out  DATA_W  memory write data.
//  mem_out      in   DATA_W  memory read data; combinational from mem_address.
// BEHAVIOUR
//  - Handshake: a beat is accepted when x_valid && x_ready. A port never sees
//    ready while its valid is low. At most one port is ready per cycle.
//  - Arbitration (combinational, from registered state):
//    - OWN_x with x_valid: grant x.
//    - Otherwise, one valid port: grant it.
//    - Both ports valid: grant the port not equal to last_gnt.
//  - FSM states: IDLE, OWN_A, OWN_B.
//    - Any state -> OWN_x on an accepted x beat with x_lock=1 and cnt+1 < MAX_BURST.
//    - Otherwise the next state is IDLE.
//    - OWN_x with x_valid=0 -> IDLE; the lock is released and nothing is accepted for x.
//  - Burst counter cnt:
//    - Reset to 0 on entry from IDLE; increments per accepted locked beat.
//    - On reaching MAX_BURST-1 the FSM returns to IDLE, so the next cycle is a
//      plain round-robin decision. If only the owner is valid, it wins again
//      and a new burst starts with cnt=0.
//  - last_gnt updates to the granted port on every accepted beat.
//  - Memory drive:
//    - Accepted beat: mem_address = x_addr, mem_in = x_wdata, mem_load = x_write.
//    - No beat: mem_load=0, mem_address=0, mem_in=0.
//  - Reads:
//    - mem_out is captured into x_rdata at the accepting edge.
//    - x_rvalid=1 for exactly the next cycle; read latency is 1 cycle.
//    - x_rdata holds its value until the next read by x.
//    - Writes produce no rvalid.
//  - Write then read, same address, consecutive cycles (either port): the read
//    returns the new data.
//  - Reset:
//    - state=IDLE, cnt=0, last_gnt=B (so A wins the first tie).
//    - a/b_rvalid=0, a/b_rdata=0.
//    - While reset=1, a/b_ready=0 and mem_load=0.
//    - Reset mid-burst drops the lock. A read accepted in the cycle before reset
//      gives no rvalid.
// STRUCTURE
//  - Shared header ram8_arb_defs.vh: state encodings (IDLE=2'd0, OWN_A=2'd1,
//    OWN_B=2'd2) and port ids (PORT_A=1'b0, PORT_B=1'b1).
//  - One sub-module, rr_pick2: 2-way round-robin picker.
//    - Inputs: req[1:0], last, force_en, force_id.
//    - Output: one-hot gnt[1:0].
//  - FSM, counter and read-data registers live in ram8_arbiter. Instantiate
//    with the existing RAM8 in the bench.
// TESTING
//  1. reset=1 for 2 cycles with both valid -> ready=0, mem_load=0, rvalid=0, rdata=0.
//  2. A writes 16'h1234 @3, then B reads @3 next cycle -> mem_load=1 on cycle 1;
//     b_rvalid=1 one cycle after acceptance; b_rdata=16'h1234.
//  3. Both valid reads, lock=0, for 6 cycles -> grants A,B,A,B,A,B; each
//     rvalid lags its grant by exactly 1 cycle.
//  4. A lock=1 with 6 read beats, B valid throughout, MAX_BURST=4 -> A,A,A,A,
//     then B, then A,A; cnt wraps cleanly.
//  5. A lock=1, only A valid, 10 beats -> A granted every cycle; bursts restart.
//  6. Reset asserted mid-burst (state OWN_B, cnt=2) -> next cycle IDLE, cnt=0,
//     no rvalid; first tie afterwards goes to A.

Source files
------------

// File: rtl/ram8_arbiter_pkg.sv
// ram8_arbiter_pkg
//   Shared definitions for the two-port RAM8 arbiter: FSM state encodings,
//   requester port identifiers and small helpers that map a port id onto
//   its one-hot grant or its "owned" FSM state.
//   Ports: none (package).
package ram8_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Grant vectors are ordered {B, A}, so bit 0 is port A.
  function automatic logic [1:0] port_onehot(input logic id);
    return (id == PORT_B) ? 2'b10 : 2'b01;
  endfunction

  function automatic arb_state_e own_state(input logic id);
    return (id == PORT_B) ? ST_OWN_B : ST_OWN_A;
  endfunction

endpackage

// File: rtl/ram8_arbiter_if.sv
// ram8_arbiter_if
//   Bundles both requester ports and the memory-side bus of the arbiter.
//   Parameters: DATA_W word width, ADDR_W word-address width.
//   Per requester x in {a, b}:
//     x_valid, x_write, x_addr, x_wdata, x_lock  requester -> arbiter
//     x_ready, x_rvalid, x_rdata                 arbiter -> requester
//   Memory side:
//     mem_load, mem_address, mem_in              arbiter -> memory
//     mem_out                                    memory -> arbiter (combinational)
//   Modports: slave = arbiter view, master = requesters + memory view.
interface ram8_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);

  logic              a_valid;
  logic              a_write;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_lock;
  logic              a_ready;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_valid;
  logic              b_write;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_lock;
  logic              b_ready;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic              mem_load;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in;
  logic [DATA_W-1:0] mem_out;

  modport slave (
    input  a_valid, a_write, a_addr, a_wdata, a_lock,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_write, b_addr, b_wdata, b_lock,
    output b_ready, b_rvalid, b_rdata,
    output mem_load, mem_address, mem_in,
    input  mem_out
  );

  modport master (
    output a_valid, a_write, a_addr, a_wdata, a_lock,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_write, b_addr, b_wdata, b_lock,
    input  b_ready, b_rvalid, b_rdata,
    input  mem_load, mem_address, mem_in,
    output mem_out
  );

endinterface

// File: rtl/ram8_arbiter_rr_pick2.sv
// rr_pick2
//   Two-way round-robin picker with an owner override.
//   Ports:
//     req[1:0]  in   request vector {B, A}
//     last      in   port id granted most recently
//     force_en  in   a port currently owns the resource
//     force_id  in   id of the owning port
//     gnt[1:0]  out  one-hot grant {B, A}, zero when nothing requests
module rr_pick2
  import ram8_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       force_en,
  input  logic       force_id,
  output logic [1:0] gnt
);

  // An owner that still requests keeps the grant; a tie goes to the port
  // that did not win last; with zero or one requester, req is already one-hot.
  always_comb begin
    gnt = 2'b00;
    if (force_en && req[force_id]) begin
      gnt = port_onehot(force_id);
    end else if (req == 2'b11) begin
      gnt = port_onehot(~last);
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/ram8_arbiter.sv
// ram8_arbiter
//   Shares one RAM8-class memory between a CPU data port (A) and a DMA /
//   peripheral port (B). Grants are round-robin; a requester may lock the
//   grant for up to MAX_BURST consecutive beats. Read data is registered
//   and returned to the winning port one cycle after acceptance.
//   Parameters: DATA_W word width, ADDR_W address width, MAX_BURST (>=1)
//   longest locked run before forced re-arbitration.
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  synchronous active-high reset
//     bus    ram8_arbiter_if.slave: both requester ports and memory bus
module ram8_arbiter
  import ram8_arbiter_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  ram8_arbiter_if.slave         bus
);

  // cnt never exceeds MAX_BURST-1, so clog2(MAX_BURST) bits suffice.
  localparam int               CNT_W      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic [1:0]        pick_gnt;
  logic [1:0]        gnt;
  logic              acc_a, acc_b, acc_any;
  logic              acc_id, acc_lock;
  logic              force_en, force_id;
  logic [CNT_W-1:0]  burst_base;

  assign force_en = (state_q != ST_IDLE);
  assign force_id = (state_q == ST_OWN_B) ? PORT_B : PORT_A;

  rr_pick2 u_pick (
    .req      ({bus.b_valid, bus.a_valid}),
    .last     (last_gnt_q),
    .force_en (force_en),
    .force_id (force_id),
    .gnt      (pick_gnt)
  );

  // Nothing may be accepted while reset is held.
  assign gnt      = reset ? 2'b00 : pick_gnt;
  assign acc_a    = gnt[0];
  assign acc_b    = gnt[1];
  assign acc_any  = acc_a | acc_b;
  assign acc_id   = acc_b ? PORT_B : PORT_A;
  assign acc_lock = acc_b ? bus.b_lock : bus.a_lock;

  // A beat continues the running count only if its port already owns the
  // grant; any other beat (from IDLE, or the other port stepping in after
  // the owner dropped valid) starts a fresh burst.
  assign burst_base = (acc_any && (state_q == own_state(acc_id))) ? cnt_q : '0;

  // State register: FSM, burst counter, round-robin history, read returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_gnt_q <= PORT_B;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Next state: stay owned only while the accepted beat asks for the lock
  // and the burst has room for another beat; everything else drops to IDLE.
  always_comb begin
    state_d    = ST_IDLE;
    cnt_d      = '0;
    last_gnt_d = last_gnt_q;
    if (acc_any) begin
      last_gnt_d = acc_id;
      if (acc_lock && (burst_base < BURST_LAST)) begin
        state_d = own_state(acc_id);
        cnt_d   = burst_base + CNT_W'(1);
      end
    end
  end

  // Read return path: capture mem_out on the accepting edge; rdata holds
  // until that port's next read.
  always_comb begin
    a_rvalid_d = acc_a && !bus.a_write;
    b_rvalid_d = acc_b && !bus.b_write;
    a_rdata_d  = a_rvalid_d ? bus.mem_out : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? bus.mem_out : b_rdata_q;
  end

  // Outputs: handshakes, memory drive (all zero when idle), read returns.
  // rvalid is masked by reset so a read accepted just before reset never
  // reports completion.
  always_comb begin
    bus.a_ready     = acc_a;
    bus.b_ready     = acc_b;
    bus.mem_load    = 1'b0;
    bus.mem_address = '0;
    bus.mem_in      = '0;
    if (acc_a) begin
      bus.mem_load    = bus.a_write;
      bus.mem_address = bus.a_addr;
      bus.mem_in      = bus.a_wdata;
    end else if (acc_b) begin
      bus.mem_load    = bus.b_write;
      bus.mem_address = bus.b_addr;
      bus.mem_in      = bus.b_wdata;
    end
    bus.a_rvalid = a_rvalid_q && !reset;
    bus.b_rvalid = b_rvalid_q && !reset;
    bus.a_rdata  = a_rdata_q;
    bus.b_rdata  = b_rdata_q;
  end

endmodule

// File: tb/tb_ram8_arbiter.sv
// tb_ram8_arbiter
//   Directed bench for ram8_arbiter with an 8 x 16-bit RAM model whose read
//   port is combinational from mem_address. The RAM is loaded with
//   16'hA000 + address whenever reset is held. A shadow copy of the memory
//   contents is kept by the bench to form expected read data.
//   Ports: none (top-level bench).
module tb_ram8_arbiter;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 3;
  localparam int MAX_BURST = 4;

  logic clk;
  logic reset;

  ram8_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram8_arbiter #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // RAM8 model: synchronous write, combinational read.
  logic [DATA_W-1:0] mem [8];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= 16'hA000 + 16'(i);
    end else if (bus.mem_load) begin
      mem[bus.mem_address] <= bus.mem_in;
    end
  end

  assign bus.mem_out = mem[bus.mem_address];

  // 100 MHz clock, first rising edge at 5 ns.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int check_count;
  int error_count;

  logic [DATA_W-1:0] shadow [8];
  int                prev_port;
  logic [DATA_W-1:0] prev_data;

  task automatic initShadow();
    for (int i = 0; i < 8; i++) shadow[i] = 16'hA000 + 16'(i);
  endtask

  task automatic applyStimulus(
    input logic av, input logic aw, input logic [2:0] aa, input logic [15:0] ad, input logic al,
    input logic bv, input logic bw, input logic [2:0] ba, input logic [15:0] bd, input logic bl
  );
    bus.a_valid = av; bus.a_write = aw; bus.a_addr = aa; bus.a_wdata = ad; bus.a_lock = al;
    bus.b_valid = bv; bus.b_write = bw; bus.b_addr = ba; bus.b_wdata = bd; bus.b_lock = bl;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_count++;
    assert (obs === exp) else begin
      error_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read cycle: drive requests, check the read return of the previous
  // cycle, check which port wins now, then advance one clock.
  // exp_port: 0 = no grant, 1 = A, 2 = B.
  task automatic beat(
    input logic av, input logic al, input logic [2:0] aa,
    input logic bv, input logic bl, input logic [2:0] ba,
    input int exp_port, input string tag
  );
    logic [2:0] exp_addr;
    applyStimulus(av, 1'b0, aa, 16'h0000, al, bv, 1'b0, ba, 16'h0000, bl);
    #1;
    checkOutput($sformatf("%s.a_rvalid", tag), 16'(bus.a_rvalid), 16'(prev_port == 1));
    checkOutput($sformatf("%s.b_rvalid", tag), 16'(bus.b_rvalid), 16'(prev_port == 2));
    if (prev_port == 1) checkOutput($sformatf("%s.a_rdata", tag), bus.a_rdata, prev_data);
    if (prev_port == 2) checkOutput($sformatf("%s.b_rdata", tag), bus.b_rdata, prev_data);
    exp_addr = (exp_port == 1) ? aa : ((exp_port == 2) ? ba : 3'd0);
    checkOutput($sformatf("%s.a_ready", tag), 16'(bus.a_ready), 16'(exp_port == 1));
    checkOutput($sformatf("%s.b_ready", tag), 16'(bus.b_ready), 16'(exp_port == 2));
    checkOutput($sformatf("%s.mem_load", tag), 16'(bus.mem_load), 16'h0000);
    checkOutput($sformatf("%s.mem_address", tag), 16'(bus.mem_address), 16'(exp_addr));
    prev_port = exp_port;
    prev_data = (exp_port == 0) ? 16'h0000 : shadow[exp_addr];
    tick();
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    check_count = 0;
    error_count = 0;
    prev_port   = 0;
    prev_data   = 16'h0000;
    initShadow();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);

    // Reset held two cycles with both ports requesting.
    #1;
    applyStimulus(1'b1, 1'b0, 3'd1, 16'h0, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0, 1'b0);
    #1;
    checkOutput("rst.a_ready", 16'(bus.a_ready), 16'h0000);
    checkOutput("rst.b_ready", 16'(bus.b_ready), 16'h0000);
    checkOutput("rst.mem_load", 16'(bus.mem_load), 16'h0000);
    tick();
    checkOutput("rst2.a_ready", 16'(bus.a_ready), 16'h0000);
    checkOutput("rst2.b_ready", 16'(bus.b_ready), 16'h0000);
    checkOutput("rst2.mem_load", 16'(bus.mem_load), 16'h0000);
    checkOutput("rst2.a_rvalid", 16'(bus.a_rvalid), 16'h0000);
    checkOutput("rst2.b_rvalid", 16'(bus.b_rvalid), 16'h0000);
    checkOutput("rst2.a_rdata", bus.a_rdata, 16'h0000);
    checkOutput("rst2.b_rdata", bus.b_rdata, 16'h0000);
    tick();
    reset = 1'b0;

    // A writes 16'h1234 to word 3, then B reads word 3 on the next cycle.
    applyStimulus(1'b1, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    #1;
    checkOutput("wr.a_ready", 16'(bus.a_ready), 16'h0001);
    checkOutput("wr.b_ready", 16'(bus.b_ready), 16'h0000);
    checkOutput("wr.mem_load", 16'(bus.mem_load), 16'h0001);
    checkOutput("wr.mem_address", 16'(bus.mem_address), 16'h0003);
    checkOutput("wr.mem_in", bus.mem_in, 16'h1234);
    shadow[3] = 16'h1234;
    tick();
    beat(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd3, 2, "wr_rd");
    beat(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 0, "wr_rd_ret");
    checkOutput("wr_rd.b_rdata_hold", bus.b_rdata, 16'h1234);

    // Both ports read, no lock: strict alternation starting with A.
    for (int i = 0; i < 6; i++)
      beat(1'b1, 1'b0, 3'(i), 1'b1, 1'b0, 3'(7 - i), (i % 2 == 0) ? 1 : 2, $sformatf("rr%0d", i));
    beat(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 0, "rr_end");

    // A locks through six reads while B keeps requesting: A,A,A,A,B,A,A.
    for (int i = 0; i < 7; i++)
      beat(1'b1, 1'b1, 3'(i), 1'b1, 1'b0, 3'd5, (i == 4) ? 2 : 1, $sformatf("lk%0d", i));
    beat(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 0, "lk_end");

    // A locks with no competitor: it wins every cycle across burst restarts.
    for (int i = 0; i < 10; i++)
      beat(1'b1, 1'b1, 3'(i), 1'b0, 1'b0, 3'd0, 1, $sformatf("solo%0d", i));
    beat(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 0, "solo_end");

    // B builds a locked burst to cnt=2, then reset lands right after a read.
    beat(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd6, 2, "mid0");
    beat(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd7, 2, "mid1");
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'd1, 16'h0, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0, 1'b1);
    #1;
    checkOutput("mid_rst.b_rvalid", 16'(bus.b_rvalid), 16'h0000);
    checkOutput("mid_rst.a_rvalid", 16'(bus.a_rvalid), 16'h0000);
    checkOutput("mid_rst.a_ready", 16'(bus.a_ready), 16'h0000);
    checkOutput("mid_rst.b_ready", 16'(bus.b_ready), 16'h0000);
    checkOutput("mid_rst.mem_load", 16'(bus.mem_load), 16'h0000);
    tick();
    reset = 1'b0;
    initShadow();
    prev_port = 0;
    checkOutput("post_rst.a_rdata", bus.a_rdata, 16'h0000);
    checkOutput("post_rst.b_rdata", bus.b_rdata, 16'h0000);
    beat(1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 3'd2, 1, "post_tie");
    beat(1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 3'd4, 2, "post_rr");
    beat(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 0, "post_end");

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
